// File: rtl/divider_pkg.sv
// Purpose: shared types and helpers for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package divider_pkg;

    // Controller states: waiting for a request, iterating, presenting results.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width for a given operand width. The counter must be
    // able to hold values up to WIDTH.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// Purpose: W-bit ripple add/subtract; mode=1 computes a - b as a + ~b + 1.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a, b  - operands
//   mode  - 0 = add, 1 = subtract
//   sum   - result (a+b or a-b, modulo 2^W)
//   cout  - carry out; in subtract mode 1 means no borrow (a >= b)
module addsub_stage #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0]   carry;
    logic [W-1:0] b_eff;

    always_comb begin
        carry    = '0;
        sum      = '0;
        b_eff    = b ^ {W{mode}};
        carry[0] = mode;
        for (int i = 0; i < W; i++) begin
            sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
        cout = carry[W];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Purpose: multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Latency: done WIDTH+1 cycles after the start edge; 1 cycle for divide-by-zero.
// Backpressure: start is only sampled while not busy; start during CALC is dropped.
//
// Ports:
//   clk, rst_n            - clock (rising edge), async active-low reset
//   start                 - request, accepted in IDLE or in the DONE cycle
//   dividend, divisor     - operands, sampled with an accepted start
//   busy                  - high while iterating
//   done                  - one-cycle pulse, results valid in that cycle
//   quotient, remainder   - results, held until overwritten by the next result
//   div_by_zero           - qualifies the results; cleared on every accepted start
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r;      // partial remainder
    logic [WIDTH-1:0] q;      // working quotient, starts as the dividend
    logic [WIDTH-1:0] dvsr;   // latched divisor

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder never exceeds the divisor, so its top bit is
    // always zero after a step; it is kept only to mirror the datapath width.
    logic unused_r_msb;
    assign unused_r_msb = r[WIDTH];

    // One restoring step: shift the next dividend bit into r, trial-subtract.
    assign r_shift = {r[WIDTH-1:0], q[WIDTH-1]};

    addsub_stage #(
        .W (WIDTH + 1)
    ) u_sub (
        .a    (r_shift),
        .b    ({1'b0, dvsr}),
        .mode (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    assign r_next = no_borrow ? diff : r_shift;
    assign q_next = {q[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            dvsr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE shares the accept path so a start in the done cycle
                // relaunches without an idle gap.
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            r     <= '0;
                            q     <= dividend;
                            dvsr  <= divisor;
                        end
                    end
                end
                CALC: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
